// File: rtl/imem_sync_loader.sv
// imem_sync_loader: instruction memory for the fetch stage.
// A fetch reads the array in its acceptance cycle. The result then passes
// through LATENCY-1 further register stages.
// A streaming load port writes a program at run time, one word per beat.
module imem_sync_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] NOP       = '0,
  parameter                    INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                wr_en;
  logic                ptr_in_range;
  logic [IDX_W-1:0]    wr_idx;

  assign ptr_in_range = {1'b0, ptr_q} < DEPTH_LIM;
  assign wr_idx       = ptr_q[IDX_W-1:0];

  // Next-state, pointer/count update and write enable for the load stream.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          ptr_d   = load_base;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_valid && ready_q) begin
          if (ptr_in_range) wr_en = 1'b1;
          else              ovf_d = 1'b1;
          // Saturate rather than wrap so a long stream can never alias low memory.
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          if (load_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
  end

  // Load FSM state and its registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    // NOTE: the memory has no reset, so it maps onto RAM and a program survives rst.
    if (wr_en) mem[wr_idx] <= load_data;
  end

  assign load_ready = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_count = count_q;
  assign load_ovf   = ovf_q;

  // ---------------------------------------------------------------------
  // Fetch pipeline
  // ---------------------------------------------------------------------
  logic                           accept;
  logic                           f_in_range;
  logic [DATA_W-1:0]              rd_word;
  logic [LATENCY-1:0]             pv_q, pv_d;
  logic [LATENCY-1:0]             pe_q, pe_d;
  logic [LATENCY-1:0][DATA_W-1:0] pd_q, pd_d;

  // Fetches are held off while the loader owns the array, so reads never see a write.
  assign fetch_ready = !rst && !busy_q;
  assign accept      = fetch_req && fetch_ready;
  assign f_in_range  = {1'b0, fetch_addr} < DEPTH_LIM;

  // Array read in the acceptance cycle; out-of-range addresses yield NOP.
  always_comb begin
    rd_word = NOP;
    if (f_in_range) rd_word = mem[fetch_addr[IDX_W-1:0]];
  end

  // Shift valid along; data/error stages load only with valid so outputs hold when idle.
  always_comb begin
    pv_d    = pv_q;
    pd_d    = pd_q;
    pe_d    = pe_q;
    pv_d[0] = accept;
    if (accept) begin
      pd_d[0] = rd_word;
      pe_d[0] = !f_in_range;
    end
    for (int k = 1; k < LATENCY; k++) begin
      pv_d[k] = pv_q[k-1];
      if (pv_q[k-1]) begin
        pd_d[k] = pd_q[k-1];
        pe_d[k] = pe_q[k-1];
      end
    end
  end

  // Fetch pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
      pd_q <= pd_d;
    end
  end

  assign fetch_valid = pv_q[LATENCY-1];
  assign fetch_data  = pd_q[LATENCY-1];
  assign fetch_err   = pe_q[LATENCY-1];

endmodule

// File: tb/tb_imem_sync_loader.sv
// Bench for imem_sync_loader: two instances (LATENCY 1 and 3) share stimulus.
// A reference model predicts each fetch result and its arrival cycle; per-instance
// monitors pop and compare whenever fetch_valid is seen.
module tb_imem_sync_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP_W = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        load_start = 1'b0;
  logic [15:0] load_base = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;

  logic        f1_ready, f1_valid, f1_err, l1_ready, l1_busy, l1_done, l1_ovf;
  logic [31:0] f1_data;
  logic [16:0] l1_count;
  logic        f3_ready, f3_valid, f3_err, l3_ready, l3_busy, l3_done, l3_ovf;
  logic [31:0] f3_data;
  logic [16:0] l3_count;

  imem_sync_loader #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(f1_ready),
    .fetch_valid(f1_valid), .fetch_data(f1_data), .fetch_err(f1_err),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(l1_ready),
    .load_busy(l1_busy), .load_done(l1_done), .load_count(l1_count), .load_ovf(l1_ovf)
  );

  imem_sync_loader #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(f3_ready),
    .fetch_valid(f3_valid), .fetch_data(f3_data), .fetch_err(f3_err),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(l3_ready),
    .load_busy(l3_busy), .load_done(l3_done), .load_count(l3_count), .load_ovf(l3_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  typedef enum {M_IDLE, M_LOAD, M_DONE} mphase_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] ref_mem [int];
  int          known[$];
  mphase_t     m_phase = M_IDLE;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;

  // One clock of stimulus: predict, then advance and check the load-side outputs.
  task automatic step(input bit freq, input logic [15:0] faddr, input bit lstart,
                      input logic [15:0] lbase, input bit lvalid,
                      input logic [31:0] ldata, input bit llast);
    exp_t x;
    int   a;
    int   n;
    fetch_req  = freq;
    fetch_addr = faddr;
    load_start = lstart;
    load_base  = lbase;
    load_valid = lvalid;
    load_data  = ldata;
    load_last  = llast;
    n = cyc;
    // A fetch is taken only while no load owns the memory; it sees pre-write contents.
    if (freq && m_phase == M_IDLE) begin
      a = int'(faddr);
      if (a >= DEPTH) begin
        x.data = NOP_W;
        x.err  = 1'b1;
      end else begin
        x.err  = 1'b0;
        x.data = ref_mem.exists(a) ? ref_mem[a] : 32'hxxxx_xxxx;
      end
      x.due = n + 1;
      q1.push_back(x);
      x.due = n + 3;
      q3.push_back(x);
    end
    case (m_phase)
      M_IDLE: if (lstart) begin
        m_ptr   = int'(lbase);
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_phase = M_LOAD;
      end
      M_LOAD: if (lvalid) begin
        if (m_ptr < DEPTH) begin
          if (!ref_mem.exists(m_ptr)) known.push_back(m_ptr);
          ref_mem[m_ptr] = ldata;
        end else begin
          m_ovf = 1'b1;
        end
        if (m_ptr < 65535) m_ptr++;
        m_cnt++;
        if (llast) m_phase = M_DONE;
      end
      M_DONE: m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    check("load_busy",        l1_busy,  m_phase != M_IDLE);
    check("load_ready",       l1_ready, m_phase == M_LOAD);
    check("load_done",        l1_done,  m_phase == M_DONE);
    check("load_count",       l1_count, m_cnt);
    check("load_ovf",         l1_ovf,   m_ovf);
    check("fetch_ready_lat1", f1_ready, m_phase == M_IDLE);
    check("fetch_ready_lat3", f3_ready, m_phase == M_IDLE);
    check("load_count_lat3",  l3_count, m_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_fetch_valid", {f3_valid, f1_valid}, 2'b00);
    check("rst_fetch_data",  {f3_data, f1_data}, 64'h0);
    check("rst_fetch_err",   {f3_err, f1_err}, 2'b00);
    check("rst_fetch_ready", {f3_ready, f1_ready}, 2'b00);
    check("rst_load_flags",  {l1_ready, l1_busy, l1_done, l1_ovf}, 4'b0000);
    check("rst_load_count",  l1_count, 17'h0);
    m_phase = M_IDLE;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    q1.delete();
    q3.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("fetch_ready_after_rst", {f3_ready, f1_ready}, 2'b11);
  endtask

  // ---------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------
  logic [31:0] last_d [2];
  bit          last_e [2];

  task automatic mon(input int id, input logic v, input logic [31:0] d, input logic e);
    exp_t  x;
    bit    empty;
    string nm;
    nm    = (id == 0) ? "lat1" : "lat3";
    empty = (id == 0) ? (q1.size() == 0) : (q3.size() == 0);
    if (!empty) x = (id == 0) ? q1[0] : q3[0];
    if (v) begin
      if (empty) begin
        check({nm, "_valid_unexpected"}, v, 1'b0);
      end else begin
        if (id == 0) void'(q1.pop_front());
        else         void'(q3.pop_front());
        check({nm, "_fetch_data"},  d,   x.data);
        check({nm, "_fetch_err"},   e,   x.err);
        check({nm, "_fetch_cycle"}, cyc, x.due);
        last_d[id] = x.data;
        last_e[id] = x.err;
      end
    end else begin
      check({nm, "_hold_data"}, d, last_d[id]);
      check({nm, "_hold_err"},  e, last_e[id]);
      if (!empty && x.due <= cyc) begin
        check({nm, "_valid_missing"}, v, 1'b1);
        if (id == 0) void'(q1.pop_front());
        else         void'(q3.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_d[0] = 32'h0;
      last_d[1] = 32'h0;
      last_e[0] = 1'b0;
      last_e[1] = 1'b0;
    end else begin
      mon(0, f1_valid, f1_data, f1_err);
      mon(1, f3_valid, f3_data, f3_err);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return 16'($urandom_range(1024, 65535));
    return 16'(known[$urandom_range(0, known.size() - 1)]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb;
    int          sent;
    bit          v;
    logic [15:0] base;

    #3;
    apply_reset();
    idle(2);

    // Program four words at base 0, then fetch them back-to-back.
    step(1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'h2001_0000 + 32'(i), i == 3);
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i), 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Five consecutive fetches: no bubbles at either latency.
    for (int i = 0; i < 5; i++) step(1'b1, 16'((7 - i) % 4), 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(5);

    // Load crossing the top of memory: two words land, two are dropped.
    step(1'b0, 16'h0, 1'b1, 16'h03FE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hA000_0000 + 32'(i), i == 3);
    idle(1);

    // Out-of-range fetch then the last in-range word.
    step(1'b1, 16'h0400, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 16'h03FF, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Pointer saturation near 2**ADDR_W; a stray load_start mid-load is ignored.
    step(1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0, 32'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hD000_0000, 1'b0);
    step(1'b0, 16'h0, 1'b1, 16'h0010, 1'b1, 32'hD000_0001, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hD000_0002, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hD000_0003, 1'b1);
    idle(1);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Reset after two of six beats; written words stay.
    step(1'b0, 16'h0, 1'b1, 16'h0100, 1'b0, 32'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hB000_0000, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 32'hB000_0001, 1'b0);
    apply_reset();
    step(1'b1, 16'h0101, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // fetch_req held across a load of address 0; same-cycle fetch sees the old word.
    step(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b1, 32'hC000_0000, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b1, 32'hC000_0001, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b1, 32'hC000_0002, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Randomised loads and fetch bursts with noise on the unused controls.
    repeat (30) begin
      base = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1018, 1023))
                                         : 16'($urandom_range(0, 1015));
      nb   = $urandom_range(1, 6);
      step($urandom_range(0, 1) == 1, rand_addr(), 1'b1, base, 1'b0, 32'h0, 1'b0);
      sent = 0;
      while (sent < nb) begin
        v = ($urandom_range(0, 3) != 0);
        step($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 3) == 0,
             16'($urandom), v, $urandom,
             v ? (sent == nb - 1) : ($urandom_range(0, 1) == 1));
        if (v) sent++;
      end
      step($urandom_range(0, 1) == 1, rand_addr(), 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
      repeat ($urandom_range(8, 16))
        step($urandom_range(0, 3) != 0, rand_addr(), 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    end

    idle(6);
    check("lat1_scoreboard_drained", q1.size(), 0);
    check("lat3_scoreboard_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
